// File: rtl/ysyx_25030093_isram.sv
// Instruction SRAM responder: valid/ready read channel with programmable latency and a backdoor image-load port.
// Optional macro ISRAM_RAND_DELAY_EN adds an LFSR-driven random extra latency of 0..7 cycles.
module ysyx_25030093_isram #(
    parameter int          DEPTH_LOG2 = 16,
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic        we,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and arready depends only on state and rst.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  eff_lat;
    logic [31:0] roff, woff;
    logic        rd_err, wr_ok, accept;

    logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

    assign roff    = araddr - BASE;
    assign woff    = waddr - BASE;
    assign rd_err  = (araddr[1:0] != 2'b00) || ((roff >> (DEPTH_LOG2 + 2)) != 32'd0);
    assign wr_ok   = ((woff >> (DEPTH_LOG2 + 2)) == 32'd0);
    assign accept  = (state_q == IDLE) && arvalid;
    assign arready = (state_q == IDLE) && !rst;
    assign rvalid  = (state_q == RESP);

`ifdef ISRAM_RAND_DELAY_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign eff_lat = 5'(LATENCY) + {2'b00, lfsr_q[2:0]};
`else
    assign eff_lat = 5'(LATENCY);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter holds the remaining WAIT cycles; leaving WAIT when it reads 1
    // gives exactly eff_lat cycles between accept and rvalid.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = eff_lat;
                    state_d = (eff_lat == 5'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q <= 5'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Word and status are captured at accept, so later backdoor writes cannot disturb the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 32'h0000_0000;
            rresp <= 2'b00;
        end else if (accept) begin
            rresp <= rd_err ? 2'b10 : 2'b00;
            rdata <= rd_err ? 32'h0000_0000 : mem[roff[DEPTH_LOG2+1:2]];
        end
    end

    always_ff @(posedge clk) begin
        if (we && wr_ok) begin
            mem[woff[DEPTH_LOG2+1:2]] <= wdata;
        end
    end

endmodule
